// File: rtl/inst_cache_pkg.sv
// Shared types, constants and address-split helpers for the instruction cache.
package inst_cache_pkg;

  localparam int DATA_WID = 32;
  localparam logic [DATA_WID-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } icache_state_t;

  function automatic int off_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  // Tag is whatever remains above the byte, word-offset and index fields.
  function automatic int tag_w(input int lines, input int line_words);
    return DATA_WID - 2 - $clog2(line_words) - $clog2(lines);
  endfunction

endpackage

// File: rtl/inst_cache_if.sv
// Fetch-side and memory-side signals of the instruction cache.
// master: fetch stage plus memory (drives pc/flush, answers requests).
// slave:  the cache itself.
import inst_cache_pkg::*;

interface inst_cache_if;
  logic [DATA_WID-1:0] pc;
  logic                flush;
  logic [DATA_WID-1:0] inst;
  logic                icache_stall;
  logic                mem_req;
  logic [DATA_WID-1:0] mem_addr;
  logic [DATA_WID-1:0] mem_rdata;
  logic                mem_ack;

  modport master (
    output pc, flush, mem_rdata, mem_ack,
    input  inst, icache_stall, mem_req, mem_addr
  );

  modport slave (
    input  pc, flush, mem_rdata, mem_ack,
    output inst, icache_stall, mem_req, mem_addr
  );
endinterface

// File: rtl/inst_cache_ram.sv
// Tag, valid and data storage for the direct-mapped instruction cache.
// Asynchronous read by line index, one data word written per cycle,
// all valid bits cleared in a single cycle.
import inst_cache_pkg::*;

module icache_ram #(
  parameter  int LINES      = 64,
  parameter  int LINE_WORDS = 4,
  localparam int OFF_W      = off_w(LINE_WORDS),
  localparam int IDX_W      = idx_w(LINES),
  localparam int TAG_W      = tag_w(LINES, LINE_WORDS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_W-1:0]    rd_idx,
  input  logic [OFF_W-1:0]    rd_off,
  output logic                rd_valid,
  output logic [TAG_W-1:0]    rd_tag,
  output logic [DATA_WID-1:0] rd_data,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [OFF_W-1:0]    wr_off,
  input  logic [DATA_WID-1:0] wr_data,
  input  logic                tag_wr,
  input  logic [TAG_W-1:0]    wr_tag,
  input  logic                clr_all
);

  logic [LINES-1:0]    valid;
  logic [TAG_W-1:0]    tag_arr  [LINES];
  logic [DATA_WID-1:0] data_arr [LINES*LINE_WORDS];

  // Combinational lookup of the line selected by the current pc.
  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tag_arr[rd_idx];
  assign rd_data  = data_arr[{rd_idx, rd_off}];

  // Valid bits: a completing refill wins over a same-cycle flush for its own line.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else begin
      if (clr_all) valid <= '0;
      if (tag_wr)  valid[wr_idx] <= 1'b1;
    end
  end

  // Tag and data arrays are not reset; valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (tag_wr) tag_arr[wr_idx] <= wr_tag;
    if (wr_en)  data_arr[{wr_idx, wr_off}] <= wr_data;
  end

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache with whole-line refill.
// Optional statistics counters are compiled in with ICACHE_STATS_EN.
//
// state  | meaning
// IDLE   | lookup pc each cycle; a miss latches the line and starts a refill
// REFILL | burst-read LINE_WORDS words from memory, word 0 first
import inst_cache_pkg::*;

module inst_cache #(
  parameter int LINES      = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  inst_cache_if.slave bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int OFF_W = off_w(LINE_WORDS);
  localparam int IDX_W = idx_w(LINES);
  localparam int TAG_W = tag_w(LINES, LINE_WORDS);
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

  icache_state_t state, state_next;

  logic [OFF_W-1:0]    cnt;
  logic [IDX_W-1:0]    line_idx;
  logic [TAG_W-1:0]    line_tag;

  logic [OFF_W-1:0]    pc_off;
  logic [IDX_W-1:0]    pc_idx;
  logic [TAG_W-1:0]    pc_tag;
  logic                pc_unused;

  logic                rd_valid;
  logic [TAG_W-1:0]    rd_tag;
  logic [DATA_WID-1:0] rd_data;
  logic                hit;
  logic                word_done;
  logic                line_done;
  logic                start_refill;

  assign pc_off    = bus.pc[OFF_W+1:2];
  assign pc_idx    = bus.pc[OFF_W+2 +: IDX_W];
  assign pc_tag    = bus.pc[DATA_WID-1 -: TAG_W];
  assign pc_unused = ^bus.pc[1:0];

  assign hit          = rd_valid && (rd_tag == pc_tag);
  assign start_refill = (state == IDLE) && !hit;
  assign word_done    = (state == REFILL) && bus.mem_ack;
  assign line_done    = word_done && (cnt == LAST_WORD);

  icache_ram #(
    .LINES      (LINES),
    .LINE_WORDS (LINE_WORDS)
  ) u_ram (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (pc_idx),
    .rd_off   (pc_off),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (word_done),
    .wr_idx   (line_idx),
    .wr_off   (cnt),
    .wr_data  (bus.mem_rdata),
    .tag_wr   (line_done),
    .wr_tag   (line_tag),
    .clr_all  (bus.flush)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state: a miss starts a refill, the last acked word ends it.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!hit)     state_next = REFILL;
      REFILL:  if (line_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs: request and address only while refilling; NOP whenever stalled.
  always_comb begin
    bus.mem_req      = 1'b0;
    bus.mem_addr     = '0;
    bus.icache_stall = 1'b1;
    bus.inst         = NOP_INST;
    case (state)
      IDLE: begin
        bus.icache_stall = !hit;
        if (hit) bus.inst = rd_data;
      end
      REFILL: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = {line_tag, line_idx, cnt, 2'b00};
      end
      default: ;
    endcase
  end

  // Refill bookkeeping: latch the missing line, then count acked words.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (start_refill) begin
      cnt      <= '0;
      line_idx <= pc_idx;
      line_tag <= pc_tag;
    end else if (word_done) begin
      cnt <= cnt + 1'b1;
    end
  end

`ifdef ICACHE_STATS_EN
  // Hit and miss statistics; survive flush, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if ((state == IDLE) && hit) hit_cnt  <= hit_cnt + 32'd1;
      if (start_refill)           miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache (LINES=64, LINE_WORDS=4).
// Memory returns {16'hC0DE, addr[15:0]} for every word.
// Stats checks are included when ICACHE_STATS_EN is defined.
module tb_inst_cache;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  inst_cache_if bus();

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  inst_cache #(.LINES(64), .LINE_WORDS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Drives pc at the current negedge, expects a miss, serves the line with
  // 'delay' idle cycles before each ack, optionally pulses flush with word
  // flush_w, and ends at the negedge where the refilled line hits.
  task automatic refill(input logic [31:0] p, input int delay, input int flush_w, input string nm);
    logic [31:0] base;
    logic [31:0] exp_addr;
    logic [31:0] exp_inst;
    int nst;
    base     = p & 32'hFFFF_FFF0;
    exp_inst = {16'hC0DE, p[15:0]};
    bus.pc = p;
    #1;
    total++;
    if (bus.icache_stall !== 1'b1 || bus.mem_req !== 1'b0 || bus.inst !== NOP) begin
      bad++;
      $display("FAIL %s miss: stall=%b req=%b inst=%h, want stall=1 req=0 inst=%h", nm, bus.icache_stall, bus.mem_req, bus.inst, NOP);
    end
    nst = 1;
    for (int w = 0; w < 4; w++) begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      bus.flush   = 1'b0;
      #1;
      exp_addr = base + 32'(w * 4);
      for (int d = 0; d < delay; d++) begin
        total++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== exp_addr || bus.icache_stall !== 1'b1) begin
          bad++;
          $display("FAIL %s wait w%0d d%0d: req=%b addr=%h stall=%b, want 1 %h 1", nm, w, d, bus.mem_req, bus.mem_addr, bus.icache_stall, exp_addr);
        end
        if (bus.icache_stall === 1'b1) nst++;
        @(negedge clk);
        #1;
      end
      total++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== exp_addr || bus.icache_stall !== 1'b1) begin
        bad++;
        $display("FAIL %s ack w%0d: req=%b addr=%h stall=%b, want 1 %h 1", nm, w, bus.mem_req, bus.mem_addr, bus.icache_stall, exp_addr);
      end
      if (bus.icache_stall === 1'b1) nst++;
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = {16'hC0DE, exp_addr[15:0]};
      if (w == flush_w) bus.flush = 1'b1;
    end
    @(negedge clk);
    bus.mem_ack = 1'b0;
    bus.flush   = 1'b0;
    #1;
    total++;
    if (bus.icache_stall !== 1'b0 || bus.inst !== exp_inst || bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0) begin
      bad++;
      $display("FAIL %s done: stall=%b inst=%h req=%b addr=%h, want 0 %h 0 0", nm, bus.icache_stall, bus.inst, bus.mem_req, bus.mem_addr, exp_inst);
    end
    total++;
    if (nst != 5 + 4 * delay) begin
      bad++;
      $display("FAIL %s stall_cycles: got %0d want %0d", nm, nst, 5 + 4 * delay);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.pc = 32'h100;
    bus.flush = 1'b0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (bus.icache_stall !== 1'b1 || bus.inst !== NOP || bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs: stall=%b inst=%h req=%b addr=%h, want 1 %h 0 0", bus.icache_stall, bus.inst, bus.mem_req, bus.mem_addr, NOP);
    end
`ifdef ICACHE_STATS_EN
    total++;
    if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
      bad++;
      $display("FAIL reset_stats: hit=%0d miss=%0d, want 0 0", hit_cnt, miss_cnt);
    end
`endif
  endtask

  task automatic test_miss();
    rst = 1'b0;
    refill(32'h100, 0, -1, "miss_100");
  endtask

  task automatic test_hit();
    @(negedge clk);
    bus.pc = 32'h108;
    #1;
    total++;
    if (bus.icache_stall !== 1'b0 || bus.inst !== 32'hC0DE_0108 || bus.mem_req !== 1'b0) begin
      bad++;
      $display("FAIL hit_108: stall=%b inst=%h req=%b, want 0 c0de0108 0", bus.icache_stall, bus.inst, bus.mem_req);
    end
    @(negedge clk);
    #1;
    total++;
    if (bus.mem_req !== 1'b0 || bus.icache_stall !== 1'b0) begin
      bad++;
      $display("FAIL hit_hold: req=%b stall=%b, want 0 0", bus.mem_req, bus.icache_stall);
    end
`ifdef ICACHE_STATS_EN
    total++;
    if (hit_cnt !== 32'd2 || miss_cnt !== 32'd1) begin
      bad++;
      $display("FAIL stats_counts: hit=%0d miss=%0d, want 2 1", hit_cnt, miss_cnt);
    end
`endif
    bus.pc = 32'h10C;
    #1;
    total++;
    if (bus.icache_stall !== 1'b0 || bus.inst !== 32'hC0DE_010C) begin
      bad++;
      $display("FAIL hit_10c: stall=%b inst=%h, want 0 c0de010c", bus.icache_stall, bus.inst);
    end
  endtask

  task automatic test_conflict();
    refill(32'h504, 0, -1, "evict_500");
    refill(32'h100, 0, -1, "refetch_100");
  endtask

  task automatic test_flush();
    bus.flush = 1'b1;
    #1;
    total++;
    if (bus.icache_stall !== 1'b0 || bus.inst !== 32'hC0DE_0100) begin
      bad++;
      $display("FAIL flush_same_cycle: stall=%b inst=%h, want 0 c0de0100", bus.icache_stall, bus.inst);
    end
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    total++;
    if (bus.icache_stall !== 1'b1) begin
      bad++;
      $display("FAIL flush_miss: stall=%b want 1", bus.icache_stall);
    end
    refill(32'h100, 0, -1, "after_flush_100");
    refill(32'h200, 0, 1, "flush_mid_200");
    bus.pc = 32'h100;
    #1;
    total++;
    if (bus.icache_stall !== 1'b1) begin
      bad++;
      $display("FAIL flush_mid_old_line: stall=%b want 1", bus.icache_stall);
    end
  endtask

  task automatic test_rst_abort();
    for (int w = 0; w < 2; w++) begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      #1;
      total++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100 + 32'(w * 4)) begin
        bad++;
        $display("FAIL abort_pre w%0d: req=%b addr=%h, want 1 %h", w, bus.mem_req, bus.mem_addr, 32'h100 + 32'(w * 4));
      end
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'hBAD0_0000 + 32'(w);
    end
    @(negedge clk);
    bus.mem_ack = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if (bus.mem_req !== 1'b0 || bus.icache_stall !== 1'b1 || bus.mem_addr !== 32'h0 || bus.inst !== NOP) begin
      bad++;
      $display("FAIL abort_rst: req=%b stall=%b addr=%h inst=%h, want 0 1 0 %h", bus.mem_req, bus.icache_stall, bus.mem_addr, bus.inst, NOP);
    end
    rst = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    refill(32'h100, 0, -1, "abort_refetch");
    bus.pc = 32'h200;
    #1;
    total++;
    if (bus.icache_stall !== 1'b1) begin
      bad++;
      $display("FAIL abort_valid_cleared: stall=%b want 1", bus.icache_stall);
    end
  endtask

  task automatic test_slow_ack();
    refill(32'h308, 3, -1, "slow_308");
    @(negedge clk);
    bus.pc = 32'h300;
    #1;
    total++;
    if (bus.icache_stall !== 1'b0 || bus.inst !== 32'hC0DE_0300) begin
      bad++;
      $display("FAIL slow_hit_300: stall=%b inst=%h, want 0 c0de0300", bus.icache_stall, bus.inst);
    end
  endtask

  initial begin
    test_reset();
    test_miss();
    test_hit();
    test_conflict();
    test_flush();
    test_rst_abort();
    test_slow_ack();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
